// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - state encodings and default widths for the shift-add multiplier control
package mult_pkg;

  localparam int N_DEFAULT = 4;

  function automatic int acc_width(input int n);
    return 2 * n + 1;
  endfunction

  // Accumulator width: N upper bits for the partial sum, one carry bit, N multiplier bits.
  localparam int MULT_W = acc_width(N_DEFAULT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mult_control_if.sv
// rtl/mult_control_if.sv - control/status signals between start logic, ACC and mult_control; Busy only with MULT_CTRL_BUSY_EN
interface mult_control_if;

  logic St;
  logic M;
  logic Load;
  logic Sh;
  logic Ad;
  logic Done;
`ifdef MULT_CTRL_BUSY_EN
  logic Busy;

  modport master (output St, M, input Load, Sh, Ad, Done, Busy);
  modport slave  (input St, M, output Load, Sh, Ad, Done, Busy);
`else
  modport master (output St, M, input Load, Sh, Ad, Done);
  modport slave  (input St, M, output Load, Sh, Ad, Done);
`endif

endinterface

// File: rtl/mult_step_counter.sv
// rtl/mult_step_counter.sv - shift-step counter; last_o flags the final multiplier bit
module mult_step_counter #(
  parameter int N = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int CNT_W = $clog2(N);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/mult_control.sv
// rtl/mult_control.sv - Load/Sh/Ad sequencer for the shift-add multiplier ACC
// Optional Busy output when MULT_CTRL_BUSY_EN is defined.
module mult_control
  import mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           Clk,
  input  logic           Rst,
  mult_control_if.slave  bus
);

  state_t state_q;
  state_t state_d;

  logic load;
  logic sh;
  logic ad;
  logic done;
  logic cnt_clr;
  logic cnt_inc;
  logic cnt_last;

  mult_step_counter #(
    .N (N)
  ) u_step_counter (
    .Clk    (Clk),
    .Rst    (Rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .last_o (cnt_last)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // S_TEST is Mealy on M: a set bit costs an extra S_SHIFT cycle after the add.
  always_comb begin
    state_d = S_IDLE;
    load    = 1'b0;
    sh      = 1'b0;
    ad      = 1'b0;
    done    = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = bus.St ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        load    = 1'b1;
        cnt_clr = 1'b1;
        state_d = S_TEST;
      end
      S_TEST: begin
        if (bus.M) begin
          ad      = 1'b1;
          state_d = S_SHIFT;
        end else begin
          sh      = 1'b1;
          cnt_inc = 1'b1;
          state_d = cnt_last ? S_DONE : S_TEST;
        end
      end
      S_SHIFT: begin
        sh      = 1'b1;
        cnt_inc = 1'b1;
        state_d = cnt_last ? S_DONE : S_TEST;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.Load = load;
  assign bus.Sh   = sh;
  assign bus.Ad   = ad;
  assign bus.Done = done;

`ifdef MULT_CTRL_BUSY_EN
  assign bus.Busy = (state_q != S_IDLE);
`endif

endmodule
